bsg_8b10b_encode_stream: RTL

BSG_8B10B_ENCODE_STREAM -- requirements
Module: bsg_8b10b_encode_stream

---
 rtl/bsg_8b10b_encode_stream.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bsg_8b10b_encode_stream.sv
// Streaming 8b/10b encoder: els_p symbols per beat, single-entry output
// register with valid/yumi handshake and running disparity carried across beats.
module bsg_8b10b_encode_stream #(
    parameter int unsigned els_p = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  v_i,
    input  logic [8*els_p-1:0]    data_i,
    input  logic [els_p-1:0]      k_i,
    output logic                  ready_o,
    output logic                  v_o,
    output logic [10*els_p-1:0]   data_o,
    input  logic                  yumi_i,
    output logic [els_p-1:0]      kerr_o,
    output logic                  kerr_sticky_o,
    output logic                  rd_o
);

    localparam int unsigned code_w_lp = 10 * els_p;

    // One lane: returns {kerr, rd_out, code[9:0]}; code bit 0 is 'a', bit 9 is 'j'.
    function automatic logic [11:0] encode_lane(input logic [7:0] sym,
                                                input logic       is_k,
                                                input logic       rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       rd6;
        logic       rd_out;
        logic       alt7;
        logic       kvalid;
        logic [9:0] code;
        x = sym[4:0];
        y = sym[7:5];
        // 5b/6b RD- codes, written in abcdei order
        case (x)
            5'd0:    s6 = 6'b100111;
            5'd1:    s6 = 6'b011101;
            5'd2:    s6 = 6'b101101;
            5'd3:    s6 = 6'b110001;
            5'd4:    s6 = 6'b110101;
            5'd5:    s6 = 6'b101001;
            5'd6:    s6 = 6'b011001;
            5'd7:    s6 = 6'b111000;
            5'd8:    s6 = 6'b111001;
            5'd9:    s6 = 6'b100101;
            5'd10:   s6 = 6'b010101;
            5'd11:   s6 = 6'b110100;
            5'd12:   s6 = 6'b001101;
            5'd13:   s6 = 6'b101100;
            5'd14:   s6 = 6'b011100;
            5'd15:   s6 = 6'b010111;
            5'd16:   s6 = 6'b011011;
            5'd17:   s6 = 6'b100011;
            5'd18:   s6 = 6'b010011;
            5'd19:   s6 = 6'b110010;
            5'd20:   s6 = 6'b001011;
            5'd21:   s6 = 6'b101010;
            5'd22:   s6 = 6'b011010;
            5'd23:   s6 = 6'b111010;
            5'd24:   s6 = 6'b110011;
            5'd25:   s6 = 6'b100110;
            5'd26:   s6 = 6'b010110;
            5'd27:   s6 = 6'b110110;
            5'd28:   s6 = 6'b001110;
            5'd29:   s6 = 6'b101110;
            5'd30:   s6 = 6'b011110;
            default: s6 = 6'b101011;
        endcase
        if (is_k && (x == 5'd28)) s6 = 6'b001111;
        // RD+ variant is the complement for unbalanced codes and for D.7
        if (rd_in && (($countones(s6) != 3) || (x == 5'd7))) s6 = ~s6;
        rd6 = rd_in ^ ($countones(s6) != 3);
        alt7 = ~is_k && (y == 3'd7) &&
               ((~rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        // 3b/4b RD- codes, written in fghj order
        if (is_k) begin
            case (y)
                3'd0:    s4 = 4'b1011;
                3'd1:    s4 = 4'b0110;
                3'd2:    s4 = 4'b1010;
                3'd3:    s4 = 4'b1100;
                3'd4:    s4 = 4'b1101;
                3'd5:    s4 = 4'b0101;
                3'd6:    s4 = 4'b1001;
                default: s4 = 4'b0111;
            endcase
        end else begin
            case (y)
                3'd0:    s4 = 4'b1011;
                3'd1:    s4 = 4'b1001;
                3'd2:    s4 = 4'b0101;
                3'd3:    s4 = 4'b1100;
                3'd4:    s4 = 4'b1101;
                3'd5:    s4 = 4'b1010;
                3'd6:    s4 = 4'b0110;
                default: s4 = alt7 ? 4'b0111 : 4'b1110;
            endcase
        end
        // every K 4b code flips with disparity; D only when unbalanced or D.x.3
        if (rd6 && (($countones(s4) != 2) || (y == 3'd3) || is_k)) s4 = ~s4;
        rd_out = rd6 ^ ($countones(s4) != 2);
        code = {s4[0], s4[1], s4[2], s4[3], s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};
        kvalid = (x == 5'd28) ||
                 ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
        return {is_k & ~kvalid, rd_out, code};
    endfunction

    logic                 v_q, v_d;
    logic [code_w_lp-1:0] data_q, data_d;
    logic [els_p-1:0]     kerr_q, kerr_d;
    logic                 rd_q, rd_d;
    logic                 sticky_q, sticky_d;

    logic [code_w_lp-1:0] enc_data;
    logic [els_p-1:0]     enc_kerr;
    logic                 enc_rd;
    logic [11:0]          lane_r;
    logic                 accept;

    // Lanes encode in wire order, each starting from the previous lane's disparity
    always_comb begin
        enc_data = '0;
        enc_kerr = '0;
        enc_rd   = rd_q;
        lane_r   = '0;
        for (int unsigned n = 0; n < els_p; n++) begin
            lane_r = encode_lane(data_i[8*n +: 8], k_i[n], enc_rd);
            enc_data[10*n +: 10] = lane_r[9:0];
            enc_kerr[n]          = lane_r[11];
            enc_rd               = lane_r[10];
        end
    end

    assign ready_o = ~reset_i & (~v_q | yumi_i);
    assign accept  = v_i & ready_o;

    // Output register next-state: load on acceptance, drop valid on a bare yumi
    always_comb begin
        v_d      = v_q;
        data_d   = data_q;
        kerr_d   = kerr_q;
        rd_d     = rd_q;
        sticky_d = sticky_q;
        if (accept) begin
            v_d      = 1'b1;
            data_d   = enc_data;
            kerr_d   = enc_kerr;
            rd_d     = enc_rd;
            sticky_d = sticky_q | (|enc_kerr);
        end else if (yumi_i) begin
            v_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q      <= 1'b0;
            data_q   <= '0;
            kerr_q   <= '0;
            rd_q     <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            v_q      <= v_d;
            data_q   <= data_d;
            kerr_q   <= kerr_d;
            rd_q     <= rd_d;
            sticky_q <= sticky_d;
        end
    end

    assign v_o           = v_q;
    assign data_o        = data_q;
    assign kerr_o        = kerr_q;
    assign rd_o          = rd_q;
    assign kerr_sticky_o = sticky_q;

endmodule
